// File: rtl/lbist_pkg.sv
// Shared definitions for the LBIST pattern fetch path: the fetch FSM state encoding,
// the skid buffer depth, and the checksum rotate amount.
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    localparam int CHK_ROT    = 1;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/pat_skid_fifo.sv
// Two-entry pattern buffer between the memory read port and the pattern consumer.
// A push and a pop in the same cycle leave the occupancy unchanged and keep order.
module pat_skid_fifo
    import lbist_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    localparam logic [1:0] depth_c = 2'(FIFO_DEPTH);

    logic [width-1:0] slot0;
    logic [width-1:0] slot1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == depth_c);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being vacated by the pop.
    assign do_push = push && (!full || do_pop);
    assign dout    = rd_ptr ? slot1 : slot0;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) slot1 <= din;
                else        slot0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)      count <= count + 2'd1;
            else if (do_pop && !do_push) count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/det_pattern_fetch.sv
// Deterministic pattern fetcher: reads num_pat words from start_add upward and streams
// them out over a valid/ready handshake. Optional checksum: DET_PATTERN_FETCH_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads while buffer credit allows
// DRAIN | all reads issued, waiting for buffer and in-flight read to empty
// DONE  | one-cycle done pulse
module det_pattern_fetch
    import lbist_pkg::*;
#(
    parameter int word_size    = 8,
    parameter int address_bits = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [address_bits-1:0] start_add,
    input  logic [address_bits:0]   num_pat,
    output logic                    mem_en,
    output logic                    mem_rw,
    output logic [address_bits-1:0] mem_add,
    input  logic [word_size-1:0]    mem_data,
    output logic                    pat_valid,
    input  logic                    pat_ready,
    output logic [word_size-1:0]    pat_data,
    output logic                    busy,
`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
    output logic [word_size-1:0]    checksum,
`endif
    output logic                    done
);

    localparam logic [address_bits:0]   cnt_one = 1;
    localparam logic [address_bits-1:0] add_one = 1;
    localparam logic [2:0]              depth_c = 3'(FIFO_DEPTH);

    fetch_state_e            state_q;
    fetch_state_e            state_d;
    logic [address_bits:0]   remaining_q;
    logic [address_bits-1:0] mem_add_q;
    logic                    inflight_q;
    logic                    mem_en_c;
    logic                    done_c;
    logic                    start_ok;
    logic                    xfer;
    logic                    issue_ok;
    logic [2:0]              slots_free;
    logic [2:0]              level_next;
    logic [word_size-1:0]    fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;

    pat_skid_fifo #(
        .width (word_size)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (mem_data),
        .pop   (xfer),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign start_ok = (state_q == IDLE) && start;
    assign xfer     = pat_valid && pat_ready;

    // A slot freed by this cycle's transfer counts as credit, so a held-high pat_ready
    // sustains one read per cycle.
    assign slots_free = depth_c - {1'b0, fifo_count} + {2'b00, xfer};
    assign issue_ok   = !(fifo_full && !xfer) && (slots_free > {2'b00, inflight_q});
    assign level_next = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};

    always_comb begin
        state_d  = state_q;
        mem_en_c = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_pat == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if ((remaining_q != '0) && issue_ok) begin
                    mem_en_c = 1'b1;
                    if (remaining_q == cnt_one) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (level_next == 3'd0) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            mem_add_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_en_c;
            if (start_ok) begin
                mem_add_q   <= start_add;
                remaining_q <= num_pat;
            end else if (mem_en_c) begin
                mem_add_q   <= mem_add_q + add_one;
                remaining_q <= remaining_q - cnt_one;
            end
        end
    end

    // Outputs are forced quiet while rst is high, not just after the reset edge.
    assign mem_en    = mem_en_c && !rst;
    assign mem_rw    = 1'b0;
    assign mem_add   = rst ? '0 : mem_add_q;
    assign pat_valid = !fifo_empty && !rst;
    assign pat_data  = pat_valid ? fifo_dout : '0;
    assign busy      = (state_q != IDLE) && !rst;
    assign done      = done_c && !rst;

`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= {checksum[word_size-1-CHK_ROT:0], checksum[word_size-1:word_size-CHK_ROT]}
                        ^ pat_data;
        end
    end
`endif

endmodule

// File: tb/tb_det_pattern_fetch.sv
// Directed self-checking bench for det_pattern_fetch; memory returns mem_add + 0x31
// one cycle after each read.
module tb_det_pattern_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_add;
    logic [8:0] num_pat;
    logic       mem_en;
    logic       mem_rw;
    logic [7:0] mem_add;
    logic [7:0] mem_data = 8'h00;
    logic       pat_valid;
    logic       pat_ready;
    logic [7:0] pat_data;
    logic       busy;
    logic       done;
`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int tests = 0;
    int fails = 0;

    det_pattern_fetch #(
        .word_size    (8),
        .address_bits (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_add (start_add),
        .num_pat   (num_pat),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_add   (mem_add),
        .mem_data  (mem_data),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .busy      (busy),
`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_data <= mem_add + 8'h31;
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_add = 8'h00; num_pat = 9'd0; pat_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (mem_en !== 1'b0)    begin fails++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
        tests++; if (mem_rw !== 1'b0)    begin fails++; $display("FAIL reset_mem_rw got %b exp 0", mem_rw); end
        tests++; if (mem_add !== 8'h00)  begin fails++; $display("FAIL reset_mem_add got %h exp 00", mem_add); end
        tests++; if (pat_valid !== 1'b0) begin fails++; $display("FAIL reset_pat_valid got %b exp 0", pat_valid); end
        tests++; if (pat_data !== 8'h00) begin fails++; $display("FAIL reset_pat_data got %h exp 00", pat_data); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int xfer = 0, done_cnt = 0, done_k = -1, rw_bad = 0;
        logic [7:0] exp;
        @(negedge clk);
        start = 1'b1; start_add = 8'h10; num_pat = 9'd4; pat_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (k == 1) begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
            end
            if (mem_rw !== 1'b0) rw_bad++;
            if (pat_valid && pat_ready) begin
                exp = 8'h10 + 8'(xfer) + 8'h31;
                tests++; if (pat_data !== exp) begin fails++; $display("FAIL basic_data[%0d] got %h exp %h", xfer, pat_data, exp); end
                tests++; if (k != 3 + xfer) begin fails++; $display("FAIL basic_xfer_cycle[%0d] got %0d exp %0d", xfer, k, 3 + xfer); end
                xfer++;
            end
            if (done) begin done_cnt++; done_k = k; end
        end
        tests++; if (xfer != 4)     begin fails++; $display("FAIL basic_count got %0d exp 4", xfer); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
        tests++; if (done_k != 7)   begin fails++; $display("FAIL basic_done_cycle got %0d exp 7", done_k); end
        tests++; if (rw_bad != 0)   begin fails++; $display("FAIL basic_mem_rw got %0d write cycles exp 0", rw_bad); end
    endtask

    task automatic test_zero();
        int en_cnt = 0, valid_cnt = 0, done_cnt = 0, done_k = -1;
        @(negedge clk);
        start = 1'b1; start_add = 8'h55; num_pat = 9'd0; pat_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (mem_en) en_cnt++;
            if (pat_valid) valid_cnt++;
            if (done) begin done_cnt++; done_k = k; end
            if (k == 2) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_after got %b exp 0", busy); end
            end
        end
        tests++; if (en_cnt != 0)    begin fails++; $display("FAIL zero_mem_en got %0d exp 0", en_cnt); end
        tests++; if (valid_cnt != 0) begin fails++; $display("FAIL zero_valid got %0d exp 0", valid_cnt); end
        tests++; if (done_cnt != 1)  begin fails++; $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); end
        tests++; if (done_k != 1)    begin fails++; $display("FAIL zero_done_cycle got %0d exp 1", done_k); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_add [4];
        logic [7:0] exp;
        int n_issue = 0, xfer = 0, done_cnt = 0;
        exp_add[0] = 8'hFE; exp_add[1] = 8'hFF; exp_add[2] = 8'h00; exp_add[3] = 8'h01;
        @(negedge clk);
        start = 1'b1; start_add = 8'hFE; num_pat = 9'd4; pat_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (mem_en) begin
                if (n_issue < 4) begin
                    tests++; if (mem_add !== exp_add[n_issue]) begin fails++; $display("FAIL wrap_add[%0d] got %h exp %h", n_issue, mem_add, exp_add[n_issue]); end
                end
                n_issue++;
            end
            if (pat_valid && pat_ready) begin
                exp = 8'hFE + 8'(xfer) + 8'h31;
                tests++; if (pat_data !== exp) begin fails++; $display("FAIL wrap_data[%0d] got %h exp %h", xfer, pat_data, exp); end
                xfer++;
            end
            if (done) done_cnt++;
        end
        tests++; if (n_issue != 4)  begin fails++; $display("FAIL wrap_reads got %0d exp 4", n_issue); end
        tests++; if (xfer != 4)     begin fails++; $display("FAIL wrap_count got %0d exp 4", xfer); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL wrap_done_cnt got %0d exp 1", done_cnt); end
    endtask

    task automatic test_stall();
        int issued = 0, xfer = 0, max_out = 0, done_cnt = 0, stall_seen = 0;
        logic       prev_stalled = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] exp;
        @(negedge clk);
        start = 1'b1; start_add = 8'h40; num_pat = 9'd8; pat_ready = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            pat_ready = !(k >= 4 && k <= 8);
            #1;
            if (prev_stalled) begin
                tests++; if (pat_data !== prev_data) begin fails++; $display("FAIL stall_stable got %h exp %h", pat_data, prev_data); end
            end
            if (pat_valid && pat_ready) begin
                exp = 8'h40 + 8'(xfer) + 8'h31;
                tests++; if (pat_data !== exp) begin fails++; $display("FAIL stall_data[%0d] got %h exp %h", xfer, pat_data, exp); end
                xfer++;
            end
            if (pat_valid && !pat_ready) stall_seen++;
            if (mem_en) issued++;
            if (issued - xfer > max_out) max_out = issued - xfer;
            if (done) done_cnt++;
            prev_stalled = pat_valid && !pat_ready;
            prev_data    = pat_data;
        end
        pat_ready = 1'b1;
        tests++; if (max_out > 2)     begin fails++; $display("FAIL stall_outstanding got %0d exp <=2", max_out); end
        tests++; if (stall_seen != 5) begin fails++; $display("FAIL stall_cycles got %0d exp 5", stall_seen); end
        tests++; if (xfer != 8)       begin fails++; $display("FAIL stall_count got %0d exp 8", xfer); end
        tests++; if (done_cnt != 1)   begin fails++; $display("FAIL stall_done_cnt got %0d exp 1", done_cnt); end
    endtask

    task automatic test_rst_mid();
        int bad = 0, xfer = 0, done_cnt = 0, done_k = -1;
        logic [7:0] exp;
        @(negedge clk);
        start = 1'b1; start_add = 8'h20; num_pat = 9'd8; pat_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (mem_en !== 1'b0)    begin fails++; $display("FAIL rstmid_mem_en got %b exp 0", mem_en); end
        tests++; if (mem_add !== 8'h00)  begin fails++; $display("FAIL rstmid_mem_add got %h exp 00", mem_add); end
        tests++; if (pat_valid !== 1'b0) begin fails++; $display("FAIL rstmid_pat_valid got %b exp 0", pat_valid); end
        tests++; if (pat_data !== 8'h00) begin fails++; $display("FAIL rstmid_pat_data got %h exp 00", pat_data); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rstmid_done got %b exp 0", done); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (pat_valid || mem_en || busy || done) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad); end
        @(negedge clk);
        start = 1'b1; start_add = 8'h30; num_pat = 9'd2;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (pat_valid && pat_ready) begin
                exp = 8'h30 + 8'(xfer) + 8'h31;
                tests++; if (pat_data !== exp) begin fails++; $display("FAIL rstmid_rerun_data[%0d] got %h exp %h", xfer, pat_data, exp); end
                xfer++;
            end
            if (done) begin done_cnt++; done_k = k; end
        end
        tests++; if (xfer != 2)     begin fails++; $display("FAIL rstmid_rerun_count got %0d exp 2", xfer); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL rstmid_rerun_done_cnt got %0d exp 1", done_cnt); end
        tests++; if (done_k != 5)   begin fails++; $display("FAIL rstmid_rerun_done_cycle got %0d exp 5", done_k); end
    endtask

`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
    task automatic test_checksum();
        @(negedge clk);
        start = 1'b1; start_add = 8'hD0; num_pat = 9'd2; pat_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (k == 1) begin
                tests++; if (checksum !== 8'h00) begin fails++; $display("FAIL chk_cleared got %h exp 00", checksum); end
            end
            if (k == 4) begin
                tests++; if (checksum !== 8'h01) begin fails++; $display("FAIL chk_first got %h exp 01", checksum); end
            end
            if (k == 5) begin
                tests++; if (checksum !== 8'h00) begin fails++; $display("FAIL chk_second got %h exp 00", checksum); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_stall();
        test_rst_mid();
`ifdef DET_PATTERN_FETCH_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/det_pattern_fetch.md
DET_PATTERN_FETCH -- requirements
Module: det_pattern_fetch

Interface
REQ-001 SHALL have parameter word_size, default 8, pattern width in bits (matches the pattern memory word).
REQ-002 SHALL have parameter address_bits, default 8, pattern memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a run; ignored unless in IDLE.
REQ-006 SHALL have port start_add  input  address_bits  first pattern address; sampled with start.
REQ-007 SHALL have port num_pat  input  address_bits+1  pattern count; sampled with start; range 0..2**address_bits.
REQ-008 SHALL have port mem_en  output  1  memory chip enable.
REQ-009 SHALL have port mem_rw  output  1  memory read/write select; 0 = read.
REQ-010 SHALL have port mem_add  output  address_bits  memory address.
REQ-011 SHALL have port mem_data  input  word_size  memory data returned one cycle after the read request.
REQ-012 SHALL have port pat_valid  output  1  pat_data holds a valid pattern.
REQ-013 SHALL have port pat_ready  input  1  downstream consumer accepts the pattern.
REQ-014 SHALL have port pat_data  output  word_size  pattern to the scan or PRPG load stage.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the last pattern is accepted.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
REQ-018 SHALL make the following transitions:
- IDLE to FETCH on start with num_pat>0.
- IDLE to DONE on start with num_pat==0.
- FETCH to DRAIN once num_pat reads have been issued.
- DRAIN to DONE when the buffer is empty and no read is in flight.
- DONE to IDLE unconditionally after one cycle.
REQ-019 SHALL drive mem_rw to 0 at all times; the block never writes the memory.
REQ-020 SHALL assert mem_en in a cycle only if free buffer slots exceed the number of reads in flight; each mem_en cycle is one read of mem_add.
REQ-021 SHALL capture mem_data into the buffer on the clock edge that ends the cycle after each issued read (read latency is 1 cycle).
REQ-022 SHALL provide a 2-entry FIFO buffer, so that back-to-back reads sustain one pattern per cycle while pat_ready is held high.
REQ-023 SHALL increment mem_add by 1 after each issued read and wrap from 2**address_bits-1 to 0.
REQ-024 SHALL treat a transfer as occurring on any cycle where pat_valid and pat_ready are both high.
REQ-025 SHALL hold pat_data stable while pat_valid is high and pat_ready is low.
REQ-026 SHALL deliver patterns in address order, with no loss and no duplication.
REQ-027 SHALL, on a simultaneous buffer capture and transfer, keep the occupancy unchanged and preserve order.
REQ-028 SHALL pulse done on the cycle of the DONE state; first pattern latency after start is 2 cycles (pat_valid high on the third edge).
REQ-029 SHALL ignore start while busy is high.

Reset
REQ-030 SHALL, while rst is high, go to IDLE and hold mem_en=0, mem_rw=0, mem_add=0, pat_valid=0, pat_data=0, busy=0 and done=0.
REQ-031 SHALL, on rst mid-run, flush the buffer and the in-flight read and discard the remaining count; no pattern is presented after reset.

Configuration
REQ-032 SHALL compile a checksum feature in only when macro DET_PATTERN_FETCH_CHECKSUM_EN is defined.
REQ-033 SHALL, with the macro defined:
- add output port checksum, width word_size;
- clear checksum on start;
- on each transfer, update checksum to (checksum rotated left by 1) XOR pat_data;
- reset checksum to 0.
REQ-034 SHALL, without the macro, omit the checksum port and its logic, with all other behaviour identical.

Structure
REQ-035 SHALL place the state encoding typedef (IDLE/FETCH/DRAIN/DONE) and the checksum rotate amount in shared package lbist_pkg.
REQ-036 SHALL implement the 2-entry buffer as sub-module pat_skid_fifo (push, pop, full, empty, count); all other logic stays flat.

Verification
REQ-037 SHALL cover: start_add=0x10, num_pat=4, pat_ready=1 -> patterns mem[0x10..0x13] on 4 consecutive cycles, done pulses 1 cycle after the last transfer.
REQ-038 SHALL cover: num_pat=0 -> no mem_en, pat_valid never asserted, done pulses on the cycle after start.
REQ-039 SHALL cover: start_add=0xFE, num_pat=4 -> mem_add sequence FE, FF, 00, 01; data in that order.
REQ-040 SHALL cover: pat_ready held low for 5 cycles mid-run -> at most 2 reads outstanding, pat_data stable, no pattern lost or duplicated.
REQ-041 SHALL cover: rst asserted 3 cycles into a num_pat=8 run -> next cycle all outputs at reset values; a new start then runs cleanly.
REQ-042 SHALL cover, with DET_PATTERN_FETCH_CHECKSUM_EN defined: patterns 0x01, 0x02 -> checksum 0x00 after start, 0x01, then 0x00.
